cmt_arbiter: RTL and testbench

CMT_ARBITER -- requirements
Module: cmt_arbiter

---
 rtl/cmt_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cmt_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmt_arbiter.sv
// cmt_arbiter: per-source completion FIFOs feeding up to NUM_PORT ROB commit ports.
// Define CMT_ARB_RR_EN for a round-robin scan; otherwise source 0 has fixed top priority.
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 2
`endif

package cmt_arbiter_pkg;
  typedef struct packed {
    logic       valid;
    logic [5:0] rob_idx;
    logic       exception;
  } RobCmtReqSt;

  typedef struct packed {
    logic ready;
  } RobCmtRspSt;
endpackage

module cmt_arbiter
  import cmt_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int NUM_PORT  = `COMMIT_WIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  RobCmtReqSt [NUM_SRC-1:0]  src_req_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  output RobCmtReqSt [NUM_PORT-1:0] cmt_req_o,
  input  RobCmtRspSt [NUM_PORT-1:0] cmt_rsp_i,
  output logic                      busy_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [CNT_W-1:0] count_q  [NUM_SRC];
  logic [CNT_W-1:0] count_d  [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_d [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_d [NUM_SRC];
  RobCmtReqSt       fifo_q   [NUM_SRC][BUF_DEPTH];
  RobCmtReqSt       fifo_d   [NUM_SRC][BUF_DEPTH];

  logic [NUM_SRC-1:0]  push;
  logic [NUM_SRC-1:0]  pop;
  logic [NUM_PORT-1:0] port_vld;
  logic [NUM_PORT-1:0] port_pop;
  logic [SRC_W-1:0]    port_src [NUM_PORT];
  logic [SRC_W-1:0]    scan_start;
  logic                out_en;

  function automatic logic [SRC_W-1:0] wrap_src(input logic [SRC_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return SRC_W'(sum);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign out_en = !rst && !flush_i;

`ifdef CMT_ARB_RR_EN
  logic [SRC_W-1:0] rr_ptr_q;
  logic [SRC_W-1:0] rr_ptr_d;

  assign scan_start = rr_ptr_q;

  // The source after the highest-numbered popping port gets first pick next cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (port_pop[k]) rr_ptr_d = wrap_src(port_src[k], 1);
    end
    if (flush_i) rr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  assign scan_start = '0;
`endif

  always_comb begin
    busy_o = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_ready_o[s] = (count_q[s] < CNT_W'(BUF_DEPTH)) && out_en;
      push[s]        = src_req_i[s].valid && src_ready_o[s];
      if (count_q[s] != '0) busy_o = 1'b1;
    end
    if (rst) busy_o = 1'b0;
  end

  // Each port takes the first not-yet-taken non-empty source in scan order, so ports fill without gaps.
  always_comb begin
    logic [NUM_SRC-1:0] taken;
    logic [SRC_W-1:0]   idx;
    logic               found;
    taken = '0;
    idx   = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      found       = 1'b0;
      port_src[k] = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        idx = wrap_src(scan_start, i);
        if (!found && !taken[idx] && (count_q[idx] != '0)) begin
          found       = 1'b1;
          port_src[k] = idx;
          taken[idx]  = 1'b1;
        end
      end
      port_vld[k] = found;
    end
  end

  always_comb begin
    cmt_req_o = '0;
    pop       = '0;
    port_pop  = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      if (port_vld[k] && out_en) begin
        cmt_req_o[k] = fifo_q[port_src[k]][rd_ptr_q[port_src[k]]];
        if (cmt_rsp_i[k].ready) begin
          port_pop[k]      = 1'b1;
          pop[port_src[k]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      count_d[s]  = count_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      wr_ptr_d[s] = push[s] ? ptr_inc(wr_ptr_q[s]) : wr_ptr_q[s];
      rd_ptr_d[s] = pop[s]  ? ptr_inc(rd_ptr_q[s]) : rd_ptr_q[s];
      if (push[s]) fifo_d[s][wr_ptr_q[s]] = src_req_i[s];
      if (flush_i) begin
        count_d[s]  = '0;
        wr_ptr_d[s] = '0;
        rd_ptr_d[s] = '0;
      end
    end
  end

  // FIFO storage is never reset; only occupancy and pointers are.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        count_q[s]  <= '0;
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_cmt_arbiter.sv
// Directed testbench for cmt_arbiter: expected commits are queued at stimulus time and
// checked by an independent monitor; level checks cover ready/busy/flush/reset/starvation.
module tb_cmt_arbiter;
   import cmt_arbiter_pkg::*;

`ifdef CMT_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   typedef struct {
      int port;
      int robIdx;
   } ExpEntry;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   RobCmtReqSt [3:0] srcReq;
   logic [3:0]       srcReady;
   RobCmtReqSt [1:0] cmtReq;
   RobCmtRspSt [1:0] cmtRsp;
   logic             busy;

   logic             flush1;
   RobCmtReqSt [3:0] src1Req;
   logic [3:0]       src1Ready;
   RobCmtReqSt [0:0] cmt1Req;
   RobCmtRspSt [0:0] cmt1Rsp;
   logic             busy1;

   ExpEntry expQ[$];
   int numCompared = 0;
   int numMismatched = 0;

   cmt_arbiter #(.NUM_SRC(4), .NUM_PORT(2), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .src_req_i(srcReq), .src_ready_o(srcReady),
      .cmt_req_o(cmtReq), .cmt_rsp_i(cmtRsp), .busy_o(busy)
   );

   cmt_arbiter #(.NUM_SRC(4), .NUM_PORT(1), .BUF_DEPTH(2)) dutOnePort (
      .clk(clk), .rst(rst), .flush_i(flush1), .src_req_i(src1Req), .src_ready_o(src1Ready),
      .cmt_req_o(cmt1Req), .cmt_rsp_i(cmt1Rsp), .busy_o(busy1)
   );

   always #5 clk = ~clk;

   // Watchdog so a stuck run still reports before stopping.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Monitor: every consumed commit on the two-port instance must match the next expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            if (cmtReq[k].valid && cmtRsp[k].ready) begin
               numCompared++;
               if (expQ.size() == 0) begin
                  numMismatched++;
                  $display("[TB] FAIL unexpectedCommit: port %0d rob %0d, expected no commit", k, cmtReq[k].rob_idx);
               end else begin
                  ExpEntry e;
                  e = expQ.pop_front();
                  if (e.port != k || e.robIdx != int'(cmtReq[k].rob_idx)) begin
                     numMismatched++;
                     $display("[TB] FAIL commitOrder: got port %0d rob %0d, expected port %0d rob %0d",
                              k, cmtReq[k].rob_idx, e.port, e.robIdx);
                  end
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      numCompared++;
      if (actual != expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int s, input logic [5:0] rob);
      srcReq[s].valid     = 1'b1;
      srcReq[s].rob_idx   = rob;
      srcReq[s].exception = 1'b0;
   endtask

   task automatic expectCommit(input int port, input int rob);
      ExpEntry e;
      e.port   = port;
      e.robIdx = rob;
      expQ.push_back(e);
   endtask

   task automatic clearSources();
      srcReq = '0;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   int servedAt;
   bit served;

   initial begin
      rst = 1'b1; flush = 1'b0; flush1 = 1'b0;
      srcReq = '0; src1Req = '0; cmtRsp = '0; cmt1Rsp = '0;

      // Reset behaviour and idle state
      stepCycle(); stepCycle();
      settle();
      checkOutput("resetReady", int'(srcReady), 0);
      checkOutput("resetBusy", int'(busy), 0);
      checkOutput("resetValid", int'({cmtReq[1].valid, cmtReq[0].valid}), 0);
      stepCycle();
      rst = 1'b0;
      settle();
      checkOutput("idleReady", int'(srcReady), 15);
      checkOutput("idleValid", int'({cmtReq[1].valid, cmtReq[0].valid}), 0);
      checkOutput("idleBusy", int'(busy), 0);

      // Four sources push at once; two ports drain them in two cycles
      stepCycle();
      cmtRsp = 2'b11;
      applyStimulus(0, 6'd5); applyStimulus(1, 6'd6); applyStimulus(2, 6'd7); applyStimulus(3, 6'd8);
      expectCommit(0, 5); expectCommit(1, 6); expectCommit(0, 7); expectCommit(1, 8);
      settle();
      checkOutput("pushNotVisibleSameCycle", int'(cmtReq[0].valid), 0);
      stepCycle();
      clearSources();
      settle();
      checkOutput("busyWithEntries", int'(busy), 1);
      stepCycle();
      stepCycle();
      settle();
      checkOutput("busyAfterDrain", int'(busy), 0);

      // Back-to-back pushes to a stalled source fill its FIFO, then drain in order
      cmtRsp = 2'b00;
      applyStimulus(1, 6'd10);
      expectCommit(0, 10); expectCommit(0, 11); expectCommit(0, 12);
      settle();
      checkOutput("src1ReadyEmpty", int'(srcReady[1]), 1);
      stepCycle();
      applyStimulus(1, 6'd11);
      settle();
      checkOutput("src1ReadyOne", int'(srcReady[1]), 1);
      stepCycle();
      applyStimulus(1, 6'd12);
      settle();
      checkOutput("src1ReadyFull", int'(srcReady[1]), 0);
      checkOutput("heldHeadRob", int'(cmtReq[0].rob_idx), 10);
      stepCycle();
      cmtRsp = 2'b11;
      settle();
      checkOutput("fullWithPopNotReady", int'(srcReady[1]), 0);
      stepCycle();
      settle();
      checkOutput("src1ReadyAfterPop", int'(srcReady[1]), 1);
      stepCycle();
      clearSources();
      stepCycle();
      settle();
      checkOutput("busyAfterFifoDrain", int'(busy), 0);

      // Port 0 stalled, port 1 ready: only the port-1 source pops
      cmtRsp = 2'b00;
      applyStimulus(0, 6'd20); applyStimulus(2, 6'd21);
      stepCycle();
      clearSources();
      cmtRsp = 2'b10;
      expectCommit(1, RrEn ? 20 : 21);
      settle();
      checkOutput("splitPort0Rob", int'(cmtReq[0].rob_idx), RrEn ? 21 : 20);
      checkOutput("splitPort1Rob", int'(cmtReq[1].rob_idx), RrEn ? 20 : 21);
      stepCycle();
      settle();
      checkOutput("persistPort0Valid", int'(cmtReq[0].valid), 1);
      checkOutput("persistPort0Rob", int'(cmtReq[0].rob_idx), RrEn ? 21 : 20);
      checkOutput("persistPort1Idle", int'(cmtReq[1].valid), 0);
      checkOutput("idlePortPayloadZero", int'(cmtReq[1]), 0);
      cmtRsp = 2'b11;
      expectCommit(0, RrEn ? 21 : 20);
      stepCycle();
      settle();
      checkOutput("busyAfterSplit", int'(busy), 0);

      // Flush with three entries buffered and a new request presented
      cmtRsp = 2'b00;
      applyStimulus(0, 6'd30); applyStimulus(1, 6'd31); applyStimulus(3, 6'd32);
      stepCycle();
      clearSources();
      flush = 1'b1;
      applyStimulus(2, 6'd33);
      settle();
      checkOutput("flushReadyLow", int'(srcReady), 0);
      checkOutput("flushValidLow", int'({cmtReq[1].valid, cmtReq[0].valid}), 0);
      checkOutput("flushBusyRegistered", int'(busy), 1);
      stepCycle();
      flush = 1'b0;
      clearSources();
      cmtRsp = 2'b11;
      settle();
      checkOutput("postFlushBusy", int'(busy), 0);
      checkOutput("postFlushReady", int'(srcReady), 15);
      checkOutput("postFlushValid", int'({cmtReq[1].valid, cmtReq[0].valid}), 0);
      stepCycle();
      stepCycle();

      // Reset mid-operation discards a pending entry
      cmtRsp = 2'b00;
      applyStimulus(0, 6'd40);
      stepCycle();
      clearSources();
      rst = 1'b1;
      settle();
      checkOutput("midResetBusy", int'(busy), 0);
      checkOutput("midResetReady", int'(srcReady), 0);
      checkOutput("midResetValid", int'(cmtReq[0].valid), 0);
      stepCycle();
      rst = 1'b0;
      cmtRsp = 2'b11;
      settle();
      checkOutput("afterResetBusy", int'(busy), 0);
      stepCycle();
      stepCycle();

      // Single-port instance: source 0 always valid, source 3 holds one entry
      cmt1Rsp = 1'b1;
      src1Req[0] = '{valid: 1'b1, rob_idx: 6'd60, exception: 1'b0};
      src1Req[3] = '{valid: 1'b1, rob_idx: 6'd50, exception: 1'b0};
      stepCycle();
      src1Req[3] = '0;
      served = 1'b0;
      servedAt = 0;
      for (int c = 1; c <= 8; c++) begin
         src1Req[0].rob_idx = 6'(60 + c);
         settle();
         if (!served && cmt1Req[0].valid && cmt1Req[0].rob_idx == 6'd50) begin
            served = 1'b1;
            servedAt = c;
         end
         stepCycle();
      end
`ifdef CMT_ARB_RR_EN
      checkOutput("rrSrc3Served", int'(served), 1);
      checkOutput("rrSrc3Within4", int'(servedAt >= 1 && servedAt <= 4), 1);
`else
      checkOutput("fixedSrc3Starved", int'(served), 0);
`endif
      src1Req[0] = '0;
      for (int c = 0; c < 4; c++) begin
         settle();
         if (!served && cmt1Req[0].valid && cmt1Req[0].rob_idx == 6'd50) served = 1'b1;
         stepCycle();
      end
      checkOutput("src3EventuallyServed", int'(served), 1);
      settle();
      checkOutput("onePortBusyDone", int'(busy1), 0);

      checkOutput("scoreboardDrained", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
